// File: rtl/tagger_uart_tx.sv
// Serial transmit path for time-tag words: a word FIFO feeding an 8N1/8N2 UART.
// Each word goes out as SYNC_BYTE followed by its data bytes, least significant byte first.
module tagger_uart_tx #(
   parameter int unsigned CLK_FREQ   = 25000000,
   parameter int unsigned BAUD       = 115200,
   parameter int unsigned WORD_BYTES = 4,
   parameter int unsigned FIFO_DEPTH = 16,
   parameter int unsigned STOP_BITS  = 1,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            word_valid,
   input  logic [8*WORD_BYTES-1:0]         word_data,
   output logic                            word_ready,
   output logic                            TxD,
   output logic                            busy,
   output logic                            overflow,
   output logic [$clog2(FIFO_DEPTH):0]     fifo_level
);

   localparam int unsigned DIV    = (CLK_FREQ + BAUD / 2) / BAUD;
   localparam int unsigned DIV_W  = $clog2(DIV);
   localparam int unsigned WORD_W = 8 * WORD_BYTES;
   localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
   localparam int unsigned LVL_W  = PTR_W + 1;
   localparam int unsigned BYTE_W = $clog2(WORD_BYTES + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t              state, stateNext;

   logic [WORD_W-1:0]   fifoMem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wrPtr, rdPtr;
   logic [LVL_W-1:0]    count;
   logic                push, pop;

   logic [DIV_W-1:0]    divCnt, divNext;
   logic [2:0]          bitCnt, bitNext;
   logic                stopCnt, stopNext;
   logic [BYTE_W-1:0]   byteIdx, byteNext;
   logic [7:0]          shiftReg, shiftNext;
   logic [WORD_W-1:0]   wordReg, wordNext;
   logic                txdNext;

   logic                bitTick, lastStop, lastByte;

   assign word_ready = (count != LVL_W'(FIFO_DEPTH));
   assign push       = word_valid & word_ready;
   assign fifo_level = count;
   assign busy       = (state != IDLE) || (count != '0);

   assign bitTick    = (divCnt == '0);
   assign lastStop   = (stopCnt == 1'(STOP_BITS - 1));
   assign lastByte   = (byteIdx == BYTE_W'(WORD_BYTES));

   // FIFO storage: written on accepted pushes only, no reset needed
   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr] <= word_data;
   end

   // FIFO pointers, fill level and overflow pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrPtr    <= '0;
         rdPtr    <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         overflow <= word_valid & ~word_ready;
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop)  rdPtr <= rdPtr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   // FSM next-state logic
   always_comb begin
      stateNext = state;
      case (state)
         IDLE:  if (count != '0) stateNext = START;
         START: if (bitTick) stateNext = DATA;
         DATA:  if (bitTick && bitCnt == 3'd7) stateNext = STOP;
         STOP:  if (bitTick && lastStop) stateNext = lastByte ? IDLE : START;
         default: stateNext = IDLE;
      endcase
   end

   // Datapath next values and next line level; TxD is driven from the register
   always_comb begin
      pop       = 1'b0;
      divNext   = divCnt;
      bitNext   = bitCnt;
      stopNext  = stopCnt;
      byteNext  = byteIdx;
      shiftNext = shiftReg;
      wordNext  = wordReg;
      txdNext   = 1'b1;
      case (state)
         IDLE: begin
            if (count != '0) begin
               pop       = 1'b1;
               divNext   = DIV_W'(DIV - 1);
               byteNext  = '0;
               shiftNext = SYNC_BYTE;
               wordNext  = fifoMem[rdPtr];
               txdNext   = 1'b0;
            end
         end
         START: begin
            txdNext = 1'b0;
            if (bitTick) begin
               divNext = DIV_W'(DIV - 1);
               bitNext = 3'd0;
               txdNext = shiftReg[0];
            end else begin
               divNext = divCnt - 1'b1;
            end
         end
         DATA: begin
            txdNext = shiftReg[0];
            if (bitTick) begin
               divNext = DIV_W'(DIV - 1);
               if (bitCnt == 3'd7) begin
                  stopNext = 1'b0;
                  txdNext  = 1'b1;
               end else begin
                  bitNext   = bitCnt + 1'b1;
                  shiftNext = shiftReg >> 1;
                  txdNext   = shiftReg[1];
               end
            end else begin
               divNext = divCnt - 1'b1;
            end
         end
         STOP: begin
            txdNext = 1'b1;
            if (bitTick) begin
               divNext = DIV_W'(DIV - 1);
               if (!lastStop) begin
                  stopNext = stopCnt + 1'b1;
               end else if (!lastByte) begin
                  byteNext  = byteIdx + 1'b1;
                  shiftNext = wordReg[7:0];
                  wordNext  = wordReg >> 8;
                  txdNext   = 1'b0;
               end
            end else begin
               divNext = divCnt - 1'b1;
            end
         end
         default: txdNext = 1'b1;
      endcase
   end

   // Datapath and line registers; reset forces the line idle immediately
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         divCnt   <= '0;
         bitCnt   <= '0;
         stopCnt  <= 1'b0;
         byteIdx  <= '0;
         shiftReg <= '0;
         wordReg  <= '0;
         TxD      <= 1'b1;
      end else begin
         divCnt   <= divNext;
         bitCnt   <= bitNext;
         stopCnt  <= stopNext;
         byteIdx  <= byteNext;
         shiftReg <= shiftNext;
         wordReg  <= wordNext;
         TxD      <= txdNext;
      end
   end

endmodule

// File: tb/tb_tagger_uart_tx.sv
// Directed bench for tagger_uart_tx: DIV=4, two-byte words, one- and two-stop-bit instances.
module tb_tagger_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n;

   logic        valid1, ready1, txd1, busy1, ovf1;
   logic [15:0] data1;
   logic [4:0]  level1;

   logic        valid2, ready2, txd2, busy2, ovf2;
   logic [15:0] data2;
   logic [4:0]  level2;

   int          checks = 0;
   int          passes = 0;

   always #5 clk = ~clk;

   tagger_uart_tx #(
      .CLK_FREQ(4), .BAUD(1), .WORD_BYTES(2), .FIFO_DEPTH(16), .STOP_BITS(1), .SYNC_BYTE(8'hA5)
   ) dut1 (
      .clk(clk), .rst_n(rst_n), .word_valid(valid1), .word_data(data1), .word_ready(ready1),
      .TxD(txd1), .busy(busy1), .overflow(ovf1), .fifo_level(level1)
   );

   tagger_uart_tx #(
      .CLK_FREQ(4), .BAUD(1), .WORD_BYTES(2), .FIFO_DEPTH(16), .STOP_BITS(2), .SYNC_BYTE(8'hA5)
   ) dut2 (
      .clk(clk), .rst_n(rst_n), .word_valid(valid2), .word_data(data2), .word_ready(ready2),
      .TxD(txd2), .busy(busy2), .overflow(ovf2), .fifo_level(level2)
   );

   // Safety net so the run can never hang
   initial begin
      #1000000;
      $display("FAIL watchdog: observed no finish, expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input logic [131:0] obs, input logic [131:0] exp, input string tag);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Samples one whole frame cycle by cycle, starting on the first start-bit cycle
   task automatic captureFrame(input int sel, input logic [15:0] w, input int stops, input string tag);
      logic [131:0] expv = '0;
      logic [131:0] got  = '0;
      logic [7:0]   bb;
      logic         v;
      int           idx = 0;
      int           n;
      n = 3 * (9 + stops) * 4;
      for (int b = 0; b < 3; b++) begin
         bb = (b == 0) ? 8'hA5 : (b == 1) ? w[7:0] : w[15:8];
         for (int p = 0; p < 9 + stops; p++) begin
            v = (p == 0) ? 1'b0 : (p <= 8) ? bb[p-1] : 1'b1;
            for (int r = 0; r < 4; r++) begin
               expv[idx] = v;
               idx++;
            end
         end
      end
      for (int i = 0; i < n; i++) begin
         got[i] = (sel == 2) ? txd2 : txd1;
         tick();
      end
      check(got, expv, tag);
   endtask

   function automatic logic [15:0] burstWord(input int i);
      return 16'(16'hB100 + i * 16'h0203);
   endfunction

   initial begin
      rst_n  = 1'b0;
      valid1 = 1'b0; data1 = '0;
      valid2 = 1'b0; data2 = '0;
      repeat (3) tick();

      // Reset state
      check(txd1, 1'b1, "rst_txd");
      check(busy1, 1'b0, "rst_busy");
      check(ovf1, 1'b0, "rst_ovf");
      check(level1, 5'd0, "rst_level");
      check(ready1, 1'b1, "rst_ready");
      check(txd2, 1'b1, "rst_txd2");
      rst_n = 1'b1;
      tick();

      // 1: single word, one idle cycle after push, 120-cycle frame
      valid1 = 1'b1; data1 = 16'h3C81;
      tick();
      valid1 = 1'b0;
      check(level1, 5'd1, "t1_level_push");
      check(txd1, 1'b1, "t1_idle_cycle");
      check(busy1, 1'b1, "t1_busy_queued");
      tick();
      check(level1, 5'd0, "t1_level_pop");
      captureFrame(1, 16'h3C81, 1, "t1_frame");
      check(txd1, 1'b1, "t1_txd_after");
      check(busy1, 1'b0, "t1_busy_after");

      // 2: two stop bits, 132-cycle frame
      valid2 = 1'b1; data2 = 16'h0000;
      tick();
      valid2 = 1'b0;
      check(txd2, 1'b1, "t2_idle_cycle");
      tick();
      captureFrame(2, 16'h0000, 2, "t2_frame");
      check(busy2, 1'b0, "t2_busy_after");

      // 3 + 6: fill FIFO while line busy, then push into a full FIFO on the pop edge
      valid1 = 1'b1; data1 = 16'h0F0F;
      tick();
      valid1 = 1'b0;
      tick();
      fork
         captureFrame(1, 16'h0F0F, 1, "t3_frame_lead");
         begin
            for (int i = 0; i < 17; i++) begin
               valid1 = 1'b1;
               data1  = burstWord(i);
               check(ready1, (i < 16) ? 1'b1 : 1'b0, $sformatf("t3_ready_%0d", i));
               tick();
               check(ovf1, (i == 16) ? 1'b1 : 1'b0, $sformatf("t3_ovf_%0d", i));
            end
            valid1 = 1'b0;
            check(level1, 5'd16, "t3_level_full");
            tick();
            check(ovf1, 1'b0, "t3_ovf_one_cycle");
         end
      join
      check(txd1, 1'b1, "t6_idle_cycle");
      check(ready1, 1'b0, "t6_ready_full");
      valid1 = 1'b1; data1 = 16'hDEAD;
      tick();
      valid1 = 1'b0;
      check(ovf1, 1'b1, "t6_ovf");
      check(level1, 5'd15, "t6_level");
      captureFrame(1, burstWord(0), 1, "t3_frame_0");
      for (int i = 1; i < 16; i++) begin
         check(txd1, 1'b1, $sformatf("t3_gap_%0d", i));
         check(level1, 5'(16 - i), $sformatf("t3_level_%0d", i));
         tick();
         captureFrame(1, burstWord(i), 1, $sformatf("t3_frame_%0d", i));
      end
      check(busy1, 1'b0, "t3_busy_after");
      check(level1, 5'd0, "t3_level_after");

      // 4: two queued words, push+pop same edge, single idle cycle between frames
      valid1 = 1'b1; data1 = 16'h6B2D;
      tick();
      data1 = 16'h94E1;
      check(level1, 5'd1, "t4_level_a");
      tick();
      valid1 = 1'b0;
      check(level1, 5'd1, "t4_level_pushpop");
      captureFrame(1, 16'h6B2D, 1, "t4_frame_a");
      check(txd1, 1'b1, "t4_gap");
      check(level1, 5'd1, "t4_level_before_pop");
      tick();
      check(level1, 5'd0, "t4_level_after_pop");
      captureFrame(1, 16'h94E1, 1, "t4_frame_b");
      check(busy1, 1'b0, "t4_busy_after");

      // 5: reset in byte 1 data bit 3, then a clean frame
      valid1 = 1'b1; data1 = 16'h1234;
      tick();
      valid1 = 1'b0;
      tick();
      valid1 = 1'b1; data1 = 16'h5555;
      tick();
      valid1 = 1'b0;
      repeat (56) tick();
      check(txd1, 1'b0, "t5_txd_bit3");
      check(level1, 5'd1, "t5_level_before");
      rst_n = 1'b0;
      #1;
      check(txd1, 1'b1, "t5_txd_reset");
      check(level1, 5'd0, "t5_level_reset");
      check(busy1, 1'b0, "t5_busy_reset");
      tick();
      rst_n = 1'b1;
      tick();
      valid1 = 1'b1; data1 = 16'hC3E7;
      tick();
      valid1 = 1'b0;
      check(txd1, 1'b1, "t5_idle_cycle");
      tick();
      captureFrame(1, 16'hC3E7, 1, "t5_frame");
      check(busy1, 1'b0, "t5_busy_after");

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
